// File: rtl/tds_pad_coincidence.sv
// N-of-4 pad coincidence on BCID-aligned TDS pad words, buffered in a small
// FWFT trigger FIFO with saturating event/overflow/mismatch statistics.
module tds_pad_coincidence #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [115:0]       pad_data_0_aligned,
    input  logic [115:0]       pad_data_1_aligned,
    input  logic [115:0]       pad_data_2_aligned,
    input  logic [115:0]       pad_data_3_aligned,
    input  logic               pad_data_valid_in,
    input  logic [1:0]         ref_layer_sel,
    input  logic [3:0]         layer_enable,
    input  logic [2:0]         coin_thresh,
    output logic               trig_valid,
    input  logic               trig_ready,
    output logic [11:0]        trig_bcid,
    output logic [3:0]         trig_layer_mask,
    output logic [103:0]       trig_pad_map,
    output logic [CNT_W-1:0]   trig_cnt,
    output logic [CNT_W-1:0]   overflow_cnt,
    output logic [CNT_W-1:0]   bcid_mismatch_cnt
);

    localparam int unsigned BCID_W = 12;
    localparam int unsigned PAD_W  = 104;
    localparam int unsigned WORD_W = 116;
    localparam int unsigned N_LYR  = 4;
    localparam int unsigned AW     = $clog2(FIFO_DEPTH);
    localparam int unsigned PW     = AW + 1;

    typedef struct packed {
        logic [BCID_W-1:0] bcid;
        logic [3:0]        mask;
        logic [PAD_W-1:0]  map;
    } trig_entry_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // Stage 1: BCID qualification against the reference layer
    logic [WORD_W-1:0] word_c [N_LYR];
    logic [BCID_W-1:0] ref_bcid_c;
    logic [3:0]        qual_c;
    logic [PAD_W-1:0]  hit_c [N_LYR];
    logic [2:0]        thresh_c;

    assign word_c[0] = pad_data_0_aligned;
    assign word_c[1] = pad_data_1_aligned;
    assign word_c[2] = pad_data_2_aligned;
    assign word_c[3] = pad_data_3_aligned;

    always_comb begin
        ref_bcid_c = word_c[ref_layer_sel][WORD_W-1:PAD_W];
        qual_c     = '0;
        for (int l = 0; l < N_LYR; l++) begin
            qual_c[l] = layer_enable[l] && (word_c[l][WORD_W-1:PAD_W] == ref_bcid_c);
            hit_c[l]  = qual_c[l] ? word_c[l][PAD_W-1:0] : '0;
        end
        thresh_c = (coin_thresh == 3'd0) ? 3'd1 : coin_thresh;
    end

    logic               s1_valid;
    logic [BCID_W-1:0]  s1_bcid;
    logic [3:0]         s1_mask;
    logic [PAD_W-1:0]   s1_hit [N_LYR];
    logic [2:0]         s1_thresh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid          <= 1'b0;
            s1_bcid           <= '0;
            s1_mask           <= '0;
            s1_thresh         <= '0;
            bcid_mismatch_cnt <= '0;
            for (int l = 0; l < N_LYR; l++) s1_hit[l] <= '0;
        end else begin
            s1_valid <= pad_data_valid_in;
            if (pad_data_valid_in) begin
                s1_bcid   <= ref_bcid_c;
                s1_mask   <= qual_c;
                s1_thresh <= thresh_c;
                for (int l = 0; l < N_LYR; l++) s1_hit[l] <= hit_c[l];
                if (|(layer_enable & ~qual_c))
                    bcid_mismatch_cnt <= sat_inc(bcid_mismatch_cnt);
            end
        end
    end

    // Stage 2: per-pad layer count against the effective threshold
    logic [2:0]       pad_cnt_c [PAD_W];
    logic [PAD_W-1:0] coin_c;
    logic             event_c;

    always_comb begin
        coin_c = '0;
        for (int p = 0; p < PAD_W; p++) begin
            pad_cnt_c[p] = 3'(s1_hit[0][p]) + 3'(s1_hit[1][p])
                         + 3'(s1_hit[2][p]) + 3'(s1_hit[3][p]);
            coin_c[p]    = (pad_cnt_c[p] >= s1_thresh);
        end
        event_c = s1_valid && (|coin_c);
    end

    logic        s2_valid;
    trig_entry_t s2_entry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_entry <= '0;
        end else begin
            s2_valid <= event_c;
            if (event_c) s2_entry <= '{bcid: s1_bcid, mask: s1_mask, map: coin_c};
        end
    end

    // Stage 3: trigger FIFO; a write becomes visible at the head one cycle later
    trig_entry_t    mem [FIFO_DEPTH];
    trig_entry_t    head_c;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  rd_ptr_nxt_c;
    logic           full_c;
    logic           rd_en_c;
    logic           wr_en_c;
    logic           drop_c;
    logic           valid_nxt_c;

    always_comb begin
        full_c       = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
        rd_en_c      = trig_valid && trig_ready;
        wr_en_c      = s2_valid && (!full_c || rd_en_c);
        drop_c       = s2_valid && full_c && !rd_en_c;
        rd_ptr_nxt_c = rd_ptr + PW'(rd_en_c);
        valid_nxt_c  = (wr_ptr != rd_ptr_nxt_c);
        head_c       = mem[rd_ptr_nxt_c[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (wr_en_c) mem[wr_ptr[AW-1:0]] <= s2_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            trig_valid      <= 1'b0;
            trig_bcid       <= '0;
            trig_layer_mask <= '0;
            trig_pad_map    <= '0;
            trig_cnt        <= '0;
            overflow_cnt    <= '0;
        end else begin
            rd_ptr     <= rd_ptr_nxt_c;
            trig_valid <= valid_nxt_c;
            if (wr_en_c) begin
                wr_ptr   <= wr_ptr + PW'(1);
                trig_cnt <= sat_inc(trig_cnt);
            end
            if (drop_c) overflow_cnt <= sat_inc(overflow_cnt);
            if (valid_nxt_c) begin
                trig_bcid       <= head_c.bcid;
                trig_layer_mask <= head_c.mask;
                trig_pad_map    <= head_c.map;
            end
        end
    end

endmodule

// File: tb/tb_tds_pad_coincidence.sv
// Randomized and directed bench for tds_pad_coincidence against a queue-level model.
module tb_tds_pad_coincidence;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = 16;

    typedef struct packed {
        logic [11:0]  bcid;
        logic [3:0]   mask;
        logic [103:0] map;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [115:0]  pd [4];
    logic          pad_data_valid_in = 1'b0;
    logic [1:0]    ref_layer_sel = 2'd0;
    logic [3:0]    layer_enable = 4'hF;
    logic [2:0]    coin_thresh = 3'd3;
    logic          trig_valid;
    logic          trig_ready = 1'b1;
    logic [11:0]   trig_bcid;
    logic [3:0]    trig_layer_mask;
    logic [103:0]  trig_pad_map;
    logic [CW-1:0] trig_cnt;
    logic [CW-1:0] overflow_cnt;
    logic [CW-1:0] bcid_mismatch_cnt;

    int n_chk = 0;
    int n_fail = 0;

    tds_pad_coincidence #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .pad_data_0_aligned(pd[0]),
        .pad_data_1_aligned(pd[1]),
        .pad_data_2_aligned(pd[2]),
        .pad_data_3_aligned(pd[3]),
        .pad_data_valid_in (pad_data_valid_in),
        .ref_layer_sel     (ref_layer_sel),
        .layer_enable      (layer_enable),
        .coin_thresh       (coin_thresh),
        .trig_valid        (trig_valid),
        .trig_ready        (trig_ready),
        .trig_bcid         (trig_bcid),
        .trig_layer_mask   (trig_layer_mask),
        .trig_pad_map      (trig_pad_map),
        .trig_cnt          (trig_cnt),
        .overflow_cnt      (overflow_cnt),
        .bcid_mismatch_cnt (bcid_mismatch_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: event rule from plain counting, FIFO as a queue
    ent_t          q[$];
    logic          pv [2];
    ent_t          pe [2];
    logic          m_valid;
    ent_t          m_head;
    logic [CW-1:0] m_trig, m_ovf, m_mis;

    function automatic void model_event(output logic ev, output ent_t e, output logic mis);
        logic [11:0] rb;
        int          th;
        int          n;
        rb = pd[ref_layer_sel][115:104];
        th = (coin_thresh == 3'd0) ? 1 : int'(coin_thresh);
        e = '0;
        e.bcid = rb;
        for (int l = 0; l < 4; l++)
            e.mask[l] = layer_enable[l] && (pd[l][115:104] == rb);
        for (int p = 0; p < 104; p++) begin
            n = 0;
            for (int l = 0; l < 4; l++)
                if (e.mask[l] && pd[l][p]) n++;
            if (n >= th) e.map[p] = 1'b1;
        end
        ev  = pad_data_valid_in && (e.map != '0);
        mis = pad_data_valid_in && ((layer_enable & ~e.mask) != 4'h0);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            pv[0] = 1'b0; pv[1] = 1'b0;
            pe[0] = '0;   pe[1] = '0;
            m_valid = 1'b0; m_head = '0;
            m_trig = '0; m_ovf = '0; m_mis = '0;
        end else begin
            logic ev, mis, rd, full, wr;
            ent_t e, we;
            model_event(ev, e, mis);
            if (mis && m_mis != '1) m_mis++;
            wr = pv[1]; we = pe[1];
            pv[1] = pv[0]; pe[1] = pe[0];
            pv[0] = ev;    pe[0] = e;
            rd   = m_valid && trig_ready;
            full = (q.size() == DEPTH);
            if (rd) void'(q.pop_front());
            m_valid = (q.size() > 0);
            if (m_valid) m_head = q[0];
            if (wr) begin
                if (!full || rd) begin
                    q.push_back(we);
                    if (m_trig != '1) m_trig++;
                end else if (m_ovf != '1) begin
                    m_ovf++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("m_valid", 128'(trig_valid), 128'(m_valid));
            check("m_bcid", 128'(trig_bcid), 128'(m_head.bcid));
            check("m_mask", 128'(trig_layer_mask), 128'(m_head.mask));
            check("m_map", 128'(trig_pad_map), 128'(m_head.map));
            check("m_trig_cnt", 128'(trig_cnt), 128'(m_trig));
            check("m_ovf_cnt", 128'(overflow_cnt), 128'(m_ovf));
            check("m_mis_cnt", 128'(bcid_mismatch_cnt), 128'(m_mis));
        end
    end

    task automatic set_all(input logic [11:0] b, input logic [103:0] h);
        for (int l = 0; l < 4; l++) pd[l] = {b, h};
    endtask

    task automatic pulse();
        pad_data_valid_in = 1'b1;
        @(negedge clk);
        pad_data_valid_in = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [103:0] one104;
    logic [103:0] r1, r2;
    logic [127:0] w1, w2;
    logic [11:0]  bsel;

    initial begin
        one104 = 104'(1);
        set_all(12'h0, '0);
        repeat (3) @(negedge clk);
        check("rst_valid", 128'(trig_valid), 128'(0));
        check("rst_trig_cnt", 128'(trig_cnt), 128'(0));
        rst_n = 1'b1;

        // Basic 4-of-4 event, visible 4 cycles after input
        set_all(12'h123, one104 << 5);
        coin_thresh = 3'd3;
        pulse();
        repeat (2) @(negedge clk);
        check("t1_early", 128'(trig_valid), 128'(0));
        @(negedge clk);
        check("t1_valid", 128'(trig_valid), 128'(1));
        check("t1_bcid", 128'(trig_bcid), 128'(12'h123));
        check("t1_mask", 128'(trig_layer_mask), 128'(4'hF));
        check("t1_map", 128'(trig_pad_map), 128'(one104 << 5));
        check("t1_cnt", 128'(trig_cnt), 128'(1));

        // Layer 2 off-BCID: 2 qualified hits on pad 7
        set_all(12'h123, one104 << 7);
        pd[2] = {12'h124, one104 << 7};
        pd[3] = {12'h123, 104'(0)};
        pulse();
        repeat (3) @(negedge clk);
        check("t2_noevt", 128'(trig_valid), 128'(0));
        check("t2_mis", 128'(bcid_mismatch_cnt), 128'(1));
        coin_thresh = 3'd2;
        pulse();
        repeat (3) @(negedge clk);
        check("t2b_valid", 128'(trig_valid), 128'(1));
        check("t2b_mask", 128'(trig_layer_mask), 128'(4'b1011));
        check("t2b_map", 128'(trig_pad_map), 128'(one104 << 7));

        // Threshold 0 acts as 1; threshold 5 never fires
        set_all(12'h055, '0);
        pd[1] = {12'h055, one104 << 103};
        coin_thresh = 3'd0;
        pulse();
        repeat (3) @(negedge clk);
        check("t3_valid", 128'(trig_valid), 128'(1));
        check("t3_map", 128'(trig_pad_map), 128'(one104 << 103));
        set_all(12'h055, '1);
        coin_thresh = 3'd5;
        pulse();
        repeat (3) @(negedge clk);
        check("t3b_noevt", 128'(trig_valid), 128'(0));
        check("t3b_cnt", 128'(trig_cnt), 128'(3));

        // Overflow: 10 events into an 8-deep stalled FIFO
        do_reset();
        trig_ready = 1'b0;
        coin_thresh = 3'd4;
        for (int i = 0; i < 10; i++) begin
            set_all(12'(12'h200 + i), 104'(1));
            pad_data_valid_in = 1'b1;
            @(negedge clk);
        end
        pad_data_valid_in = 1'b0;
        repeat (4) @(negedge clk);
        check("t4_cnt", 128'(trig_cnt), 128'(8));
        check("t4_ovf", 128'(overflow_cnt), 128'(2));
        for (int k = 0; k < 3; k++) begin
            check("t4_stall_bcid", 128'(trig_bcid), 128'(12'h200));
            check("t4_stall_valid", 128'(trig_valid), 128'(1));
            @(negedge clk);
        end
        trig_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t4_drain", 128'(trig_bcid), 128'(12'h200 + i));
            @(negedge clk);
        end
        check("t4_empty", 128'(trig_valid), 128'(0));
        check("t4_retain", 128'(trig_bcid), 128'(12'h207));

        // Full FIFO with a read on the same edge as a new write
        do_reset();
        trig_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_all(12'(12'h300 + i), 104'(1));
            pad_data_valid_in = 1'b1;
            @(negedge clk);
        end
        pad_data_valid_in = 1'b0;
        repeat (4) @(negedge clk);
        set_all(12'h308, 104'(1));
        pulse();
        @(negedge clk);
        trig_ready = 1'b1;
        @(negedge clk);
        check("t5_ovf", 128'(overflow_cnt), 128'(0));
        check("t5_cnt", 128'(trig_cnt), 128'(9));
        for (int i = 1; i < 9; i++) begin
            check("t5_order", 128'(trig_bcid), 128'(12'h300 + i));
            @(negedge clk);
        end
        check("t5_empty", 128'(trig_valid), 128'(0));

        // Reset with 3 buffered and 2 in flight
        do_reset();
        trig_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_all(12'(12'h400 + i), 104'(1));
            pad_data_valid_in = 1'b1;
            @(negedge clk);
        end
        pad_data_valid_in = 1'b0;
        check("t6_pre_cnt", 128'(trig_cnt), 128'(3));
        rst_n = 1'b0;
        #1;
        check("t6_valid", 128'(trig_valid), 128'(0));
        check("t6_cnt", 128'(trig_cnt), 128'(0));
        check("t6_ovf", 128'(overflow_cnt), 128'(0));
        check("t6_mis", 128'(bcid_mismatch_cnt), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("t6_stale", 128'(trig_valid), 128'(0));
        check("t6_cnt_after", 128'(trig_cnt), 128'(0));

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            pad_data_valid_in = ($urandom_range(0, 3) != 0);
            ref_layer_sel = 2'($urandom_range(0, 3));
            layer_enable  = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'hF;
            coin_thresh   = 3'($urandom_range(0, 7));
            trig_ready    = ($urandom_range(0, 3) != 0);
            for (int l = 0; l < 4; l++) begin
                w1 = {$urandom(), $urandom(), $urandom(), $urandom()};
                w2 = {$urandom(), $urandom(), $urandom(), $urandom()};
                r1 = w1[103:0];
                r2 = w2[103:0];
                bsel = ($urandom_range(0, 4) == 0) ? 12'h101 : 12'h100;
                pd[l] = {bsel, r1 & r2};
            end
            @(negedge clk);
        end
        pad_data_valid_in = 1'b0;
        trig_ready = 1'b1;
        repeat (DEPTH + 6) @(negedge clk);
        check("end_empty", 128'(trig_valid), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tds_pad_coincidence.md
Name: tds_pad_coincidence

Overview:
- Sits directly downstream of the TDS link latency alignment stage.
- Consumes the four BCID-aligned 116-bit pad words: bits [115:104] are the BCID, bits [103:0] are the per-pad hit map.
- Qualifies each layer by BCID agreement with a reference layer, then forms a programmable N-of-4 pad coincidence.
- Coincident events are pushed into a small first-word-fall-through (FWFT) FIFO, drained over a valid/ready handshake toward the trigger-info packer, with event and overflow statistics kept alongside.

Parameters:
- FIFO_DEPTH, 8: trigger FIFO entries; power of two, 4..64.
- CNT_W, 16: width of the saturating statistics counters.

Ports:
- clk  in  1  single design clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- pad_data_0_aligned  in  116  layer 0 aligned word.
- pad_data_1_aligned  in  116  layer 1 aligned word.
- pad_data_2_aligned  in  116  layer 2 aligned word.
- pad_data_3_aligned  in  116  layer 3 aligned word.
- pad_data_valid_in  in  1  input words valid this cycle.
- ref_layer_sel  in  2  layer whose BCID is the event BCID.
- layer_enable  in  4  per-layer participation enable.
- coin_thresh  in  3  minimum number of qualified layers hit per pad.
- trig_valid  out  1  FIFO head valid.
- trig_ready  in  1  consumer accepts head.
- trig_bcid  out  12  event BCID of head.
- trig_layer_mask  out  4  qualified layers of head event.
- trig_pad_map  out  104  coincident pads of head event.
- trig_cnt  out  CNT_W  events written to FIFO, saturating.
- overflow_cnt  out  CNT_W  events dropped because FIFO full, saturating.
- bcid_mismatch_cnt  out  CNT_W  valid cycles with at least one enabled layer disqualified, saturating.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO emptied; trig_valid=0.
  - trig_bcid, trig_layer_mask, trig_pad_map = 0.
  - All counters = 0.
  - Pipeline valid bits cleared.
  - Reset mid-operation discards all in-flight and buffered events.
- Stage 1 (registered on pad_data_valid_in=1):
  - Capture all four words.
  - ref_bcid = BCID of layer ref_layer_sel.
  - Layer L is qualified when layer_enable[L]=1 and its BCID equals ref_bcid.
  - layer_mask = the 4 qualified bits.
  - Hit maps of unqualified layers are forced to 0.
  - bcid_mismatch_cnt increments when (layer_enable & ~layer_mask) != 0.
  - Reference layer disabled: still provides ref_bcid, contributes no hits.
- Stage 2 (registered):
  - For each of the 104 pads, count the qualified layers hit (0..4).
  - A pad is coincident when count >= effective threshold.
  - Effective threshold: coin_thresh=0 is treated as 1; coin_thresh of 5..7 never fires.
  - Event is generated when any pad is coincident.
  - coin_thresh and layer_enable are sampled in stage 1 and travel with the event, so a mid-stream change affects only later inputs.
- Stage 3: an event writes {ref_bcid, layer_mask, coincident map} into the FIFO.
  - Input-valid to FIFO-write latency: 3 clk.
  - Event-to-trig_valid latency when the FIFO was empty: 4 clk.
- Write rules:
  - FIFO not full: write; trig_cnt increments.
  - FIFO full and no read in the same cycle: event dropped; overflow_cnt increments; FIFO contents unchanged.
  - FIFO full with a read in the same cycle: write accepted.
  - Simultaneous read and write on an empty FIFO: not possible in FWFT mode; the write lands, and trig_valid rises the next cycle.
- Read rules:
  - Head is presented FWFT.
  - Transfer occurs when trig_valid && trig_ready.
  - Outputs are stable while trig_valid=1 and trig_ready=0.
  - Output fields retain the last value when the FIFO is empty.
- Pointers: log2(FIFO_DEPTH)+1 bits, wrapping naturally. Full = equal indices with differing MSB; empty = pointers equal.
- Counters: saturate at all-ones and never wrap.
- Throughput: one event per clk sustained when trig_ready=1. The pipeline never back-pressures upstream; there is no input ready.

Test Plan:
- Reset, then all four layers with BCID 0x123 and bit 5 set, coin_thresh=3, layer_enable=4'hF, trig_ready=1 -> trig_valid on cycle 4 with trig_bcid=0x123, trig_layer_mask=4'hF, trig_pad_map bit 5 only; trig_cnt=1.
- Layer 2 BCID 0x124, others 0x123, pad 7 hit on layers 0,1,2, coin_thresh=3 -> no event; bcid_mismatch_cnt=1. Repeat with coin_thresh=2 -> event with trig_layer_mask=4'b1011 and pad 7 set.
- coin_thresh=0 with a single-layer hit on pad 103 -> event with trig_pad_map bit 103. coin_thresh=5 with all layers hitting all pads -> no event.
- trig_ready=0 and 10 back-to-back events (FIFO_DEPTH=8) -> trig_cnt=8, overflow_cnt=2. Drain gives the first 8 BCIDs in order, stable while stalled.
- FIFO full, then trig_ready=1 while a new event arrives in the same cycle -> write accepted, no overflow increment, order preserved.
- rst_n pulled low mid-burst with 3 events buffered and 2 in flight -> trig_valid=0 immediately, all counters 0, no stale events after release.
